// File: rtl/onehot_pulse_decoder_pkg.sv
// Shared constants and state encoding for the one-hot pulse decoder.
package onehot_pulse_decoder_pkg;
    localparam int NUM_LINES = 8;
    localparam int IDX_W     = 3;
    localparam int CNT_W     = 8;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
endpackage

// File: rtl/onehot_pulse_decoder_dec3to8.sv
// Combinational 3-to-8 one-hot decode used for the pulse load value.
module onehot_dec3to8
    import onehot_pulse_decoder_pkg::*;
(
    input  logic [IDX_W-1:0]     idx,
    output logic [NUM_LINES-1:0] y
);
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            assign y[gi] = (idx == IDX_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/onehot_pulse_decoder.sv
// Regenerates a one-hot strobe of PULSE_LEN cycles from an encoded index,
// followed by a GAP_LEN-cycle quiet interval; one pending entry is buffered.
module onehot_pulse_decoder
    import onehot_pulse_decoder_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IDX_W-1:0]     in_idx,
    input  logic                 in_idle,
    output logic [NUM_LINES-1:0] h,
    output logic                 busy,
    output logic [CNT_W-1:0]     idle_cnt
);
    localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD   = CNT_W'(GAP_LEN - 1);

    state_t                 state_reg;
    logic [NUM_LINES-1:0]   h_reg;
    logic                   pend_v_reg;
    logic [IDX_W-1:0]       pend_idx_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       idle_cnt_reg;
    logic [NUM_LINES-1:0]   dec_h;
    logic                   xfer;

    onehot_dec3to8 u_dec (
        .idx (pend_idx_reg),
        .y   (dec_h)
    );

    assign in_ready = ~pend_v_reg;
    assign xfer     = in_valid & ~pend_v_reg;
    assign h        = h_reg;
    assign busy     = (state_reg != ST_IDLE) | pend_v_reg;
    assign idle_cnt = idle_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            h_reg        <= '0;
            pend_v_reg   <= 1'b0;
            pend_idx_reg <= '0;
            cnt_reg      <= '0;
            idle_cnt_reg <= '0;
        end else begin
            // An accept only happens with the pending slot empty, so it never
            // races the load below, which requires the slot to be full.
            if (xfer) begin
                if (in_idle) begin
                    if (idle_cnt_reg != {CNT_W{1'b1}})
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                end else begin
                    pend_v_reg   <= 1'b1;
                    pend_idx_reg <= in_idx;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    h_reg <= '0;
                    if (pend_v_reg) begin
                        state_reg  <= ST_PULSE;
                        h_reg      <= dec_h;
                        pend_v_reg <= 1'b0;
                        cnt_reg    <= PULSE_RELOAD;
                    end
                end
                ST_PULSE: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        state_reg <= ST_GAP;
                        h_reg     <= '0;
                        cnt_reg   <= GAP_RELOAD;
                    end
                end
                ST_GAP: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else if (pend_v_reg) begin
                        state_reg  <= ST_PULSE;
                        h_reg      <= dec_h;
                        pend_v_reg <= 1'b0;
                        cnt_reg    <= PULSE_RELOAD;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    h_reg     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Randomised and directed bench for onehot_pulse_decoder against a
// timestamp-based schedule model (pulse start = max(accept+1, prev start+P+G)).
module tb_onehot_pulse_decoder;
    localparam int PL  = 4;
    localparam int GL  = 1;
    localparam int PL2 = 1;
    localparam int GL2 = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_idle;
    logic [2:0] in_idx;
    logic       in_ready, busy;
    logic [7:0] h, idle_cnt;

    logic       v2;
    logic [2:0] idx2;
    logic       in_ready2, busy2;
    logic [7:0] h_2, idle_cnt2;

    always #5 clk = ~clk;

    onehot_pulse_decoder #(.PULSE_LEN(PL), .GAP_LEN(GL)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_idle(in_idle), .h(h), .busy(busy), .idle_cnt(idle_cnt)
    );

    onehot_pulse_decoder #(.PULSE_LEN(PL2), .GAP_LEN(GL2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(in_ready2),
        .in_idx(idx2), .in_idle(1'b0), .h(h_2), .busy(busy2), .idle_cnt(idle_cnt2)
    );

    int passed = 0;
    int total  = 0;
    int n      = 0;

    // reference model state
    logic       m_pend_v;
    logic [2:0] m_pend_idx;
    int         m_cur_start;
    int         m_cur_idx;
    int         m_next_allowed;
    int         m_idle;
    logic       last_xfer;

    // observed pulse starts
    logic [7:0] prev_h, prev_h2;
    int         starts[$];
    logic [7:0] vals[$];
    int         starts2[$];
    logic [7:0] vals2[$];
    int         high2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, n);
    endtask

    task automatic model_reset();
        m_pend_v       = 1'b0;
        m_pend_idx     = '0;
        m_cur_start    = -1000;
        m_cur_idx      = 0;
        m_next_allowed = 0;
        m_idle         = 0;
        prev_h         = '0;
        prev_h2        = '0;
    endtask

    task automatic step();
        logic [7:0] exp_h;
        logic       xfer;
        @(posedge clk);
        n++;
        xfer = in_valid && !m_pend_v;
        if (m_pend_v && n >= m_next_allowed) begin
            m_cur_start    = n;
            m_cur_idx      = int'(m_pend_idx);
            m_next_allowed = n + PL + GL;
            m_pend_v       = 1'b0;
        end
        if (xfer) begin
            $display("edge %0d: transfer idx=%0d idle=%0b", n, in_idx, in_idle);
            if (in_idle) m_idle = (m_idle < 255) ? m_idle + 1 : 255;
            else begin
                m_pend_v   = 1'b1;
                m_pend_idx = in_idx;
            end
        end
        last_xfer = xfer;
        #1;
        exp_h = (n - m_cur_start < PL) ? (8'h01 << m_cur_idx) : 8'h00;
        chk("h", h, exp_h);
        chk("in_ready", in_ready, !m_pend_v);
        chk("busy", busy, m_pend_v || (n < m_next_allowed));
        chk("idle_cnt", idle_cnt, m_idle);
        chk("onehot0", $onehot0(h), 1);
        if (h != 8'h00 && prev_h == 8'h00) begin
            starts.push_back(n);
            vals.push_back(h);
        end
        if (h_2 != 8'h00) high2++;
        if (h_2 != 8'h00 && prev_h2 == 8'h00) begin
            starts2.push_back(n);
            vals2.push_back(h_2);
        end
        prev_h  = h;
        prev_h2 = h_2;
    endtask

    task automatic offer(input logic [2:0] idx, input logic idle);
        in_valid = 1'b1;
        in_idx   = idx;
        in_idle  = idle;
        last_xfer = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (last_xfer) break;
        end
        if (!last_xfer) chk("offer_timeout", last_xfer, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int cycles);
        in_valid = 1'b0;
        for (int k = 0; k < cycles; k++) step();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_idx   = '0;
        in_idle  = 1'b0;
        v2       = 1'b0;
        idx2     = '0;
        high2    = 0;
        last_xfer = 1'b0;
        model_reset();
        #12;
        chk("rst_h", h, 8'h00);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_idle_cnt", idle_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single pulse, idx 5, transfer at edge 1
        in_valid = 1'b1; in_idx = 3'd5; in_idle = 1'b0;
        step();
        in_valid = 1'b0;
        chk("single_ready_low", in_ready, 0);
        for (int k = 2; k <= 7; k++) begin
            step();
            chk("single_ready", in_ready, 1);
            if (k <= 5) chk("single_h", h, 8'h20);
            if (k == 6) chk("single_h_off", h, 8'h00);
            if (k == 7) chk("single_busy", busy, 0);
        end

        // back-to-back with continuous valid
        starts.delete(); vals.delete();
        offer(3'd0, 1'b0);
        offer(3'd7, 1'b0);
        drain(14);
        chk("b2b_count", starts.size(), 2);
        if (starts.size() == 2) begin
            chk("b2b_v0", vals[0], 8'h01);
            chk("b2b_v1", vals[1], 8'h80);
            chk("b2b_spacing", starts[1] - starts[0], PL + GL);
        end

        // backpressure: three offers back to back
        starts.delete(); vals.delete();
        offer(3'd1, 1'b0);
        offer(3'd2, 1'b0);
        chk("bp_ready_low", in_ready, 0);
        offer(3'd3, 1'b0);
        drain(20);
        chk("bp_count", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("bp_v0", vals[0], 8'h02);
            chk("bp_v1", vals[1], 8'h04);
            chk("bp_v2", vals[2], 8'h08);
        end

        // no-op saturation
        starts.delete(); vals.delete();
        for (int k = 0; k < 300; k++) offer(3'($urandom_range(0, 7)), 1'b1);
        chk("noop_pulses", starts.size(), 0);
        chk("noop_busy", busy, 0);
        chk("noop_sat", idle_cnt, 8'd255);
        offer(3'd3, 1'b0);
        drain(8);
        chk("noop_after", vals.size() == 1 ? vals[0] : 8'hxx, 8'h08);

        // randomised traffic
        for (int k = 0; k < 400; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_idx   = 3'($urandom_range(0, 7));
            in_idle  = ($urandom_range(0, 3) == 0);
            step();
        end
        drain(20);

        // asynchronous reset mid-pulse with a pending entry
        offer(3'd6, 1'b0);
        offer(3'd2, 1'b0);
        chk("mid_pulse_h", h, 8'h40);
        chk("mid_pend", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_h", h, 8'h00);
        chk("arst_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_idle_cnt", idle_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        starts.delete(); vals.delete();
        drain(15);
        chk("arst_no_pulse", starts.size(), 0);

        // parameter sweep on the PULSE_LEN=1, GAP_LEN=255 instance
        starts2.delete(); vals2.delete(); high2 = 0;
        v2 = 1'b1; idx2 = 3'd1;
        step();
        idx2 = 3'd6;
        for (int k = 0; k < 10; k++) begin
            automatic logic rdy = in_ready2;
            step();
            if (rdy) break;
        end
        v2 = 1'b0;
        drain(600);
        chk("sweep_count", starts2.size(), 2);
        chk("sweep_high_cycles", high2, 2);
        if (starts2.size() == 2) begin
            chk("sweep_v0", vals2[0], 8'h02);
            chk("sweep_v1", vals2[1], 8'h40);
            chk("sweep_spacing", starts2[1] - starts2[0], PL2 + GL2);
        end
        chk("sweep_busy_end", busy2, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
